// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 64;
    localparam int PC_STEP = 4;

    typedef enum logic [0:0] {
        FQ_RUN   = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Synchronous (pc, instr) FIFO whose head is held in a register so that
// the head entry stays stable (and keeps its last value once empty).
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fq_entry_t        push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fq_entry_t        head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fq_entry_t        r_head;

    logic             w_do_pop;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_after_pop;
    logic [CNT_W-1:0] w_count_nxt;
    fq_entry_t        w_head_nxt;

    assign w_do_pop = pop && (r_count != '0);
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign head     = r_head;

    // Next pointer/count and next head: an existing entry wins over a new push.
    always_comb begin
        w_rd_ptr_nxt    = r_rd_ptr + PTR_W'(w_do_pop);
        w_cnt_after_pop = r_count - CNT_W'(w_do_pop);
        w_count_nxt     = w_cnt_after_pop + CNT_W'(push);
        if (w_cnt_after_pop != '0) begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end else if (push) begin
            w_head_nxt = push_data;
        end else begin
            w_head_nxt = r_head;
        end
    end

    // Storage, pointers and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1'b1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_head   <= w_head_nxt;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order
// response buffering and wrong-path discard on redirect.
// Optional 0-cycle response bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                mem_req_valid,
    output logic [XLEN-1:0]     mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [INSTR_W-1:0]  mem_rsp_data,
    output logic                out_valid,
    output logic [XLEN-1:0]     out_pc,
    output logic [INSTR_W-1:0]  out_instr,
    input  logic                out_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_resp_pc;
    logic [OUT_W-1:0] r_outstanding;
    logic [OUT_W-1:0] r_discard;
    fq_state_t        r_state;
    logic             r_started;

    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    fq_entry_t        w_fifo_head;
    fq_entry_t        w_push_data;
    logic [31:0]      w_inflight;
    logic             w_credit;
    logic             w_fire;
    logic             w_rsp;
    logic             w_drop;
    logic             w_accept;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic [OUT_W-1:0] w_out_after_rsp;

    // Slots already claimed: buffered words plus in-flight words that will be kept.
    assign w_inflight = 32'(w_fifo_count) + 32'(r_outstanding) - 32'(r_discard);
    assign w_credit   = (32'(r_outstanding) < 32'(MAX_OUT)) && (w_inflight < 32'(DEPTH));

    assign mem_req_valid = r_started && w_credit && !redirect_valid;
    assign mem_req_addr  = r_fetch_pc;
    assign w_fire        = mem_req_valid && mem_req_ready;

    assign w_rsp           = mem_rsp_valid && (r_outstanding != '0);
    assign w_out_after_rsp = r_outstanding - OUT_W'(w_rsp);
    assign w_drop          = redirect_valid || (r_state == FQ_DRAIN);
    assign w_accept        = w_rsp && r_started && !w_drop;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_accept && w_fifo_empty && out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop       = !w_fifo_empty && out_ready;
    assign w_push      = w_accept && !w_bypass && (!w_fifo_full || w_pop);
    assign w_push_data = '{pc: r_resp_pc, instr: mem_rsp_data};

    assign out_valid = w_bypass || !w_fifo_empty;
    assign out_pc    = w_bypass ? r_resp_pc    : w_fifo_head.pc;
    assign out_instr = w_bypass ? mem_rsp_data : w_fifo_head.instr;

    fq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count),
        .head      (w_fifo_head)
    );

    // Fetch/response PCs, request accounting and RUN/DRAIN control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_state       <= FQ_RUN;
            r_started     <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc    <= redirect_pc;
                r_resp_pc     <= redirect_pc;
                r_outstanding <= w_out_after_rsp;
                r_discard     <= w_out_after_rsp;
                r_state       <= (w_out_after_rsp != '0) ? FQ_DRAIN : FQ_RUN;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= pc_next(r_fetch_pc);
                end
                if (w_accept) begin
                    r_resp_pc <= pc_next(r_resp_pc);
                end
                r_outstanding <= w_out_after_rsp + OUT_W'(w_fire);
                case (r_state)
                    FQ_DRAIN: begin
                        if (w_rsp) begin
                            r_discard <= r_discard - OUT_W'(1'b1);
                            r_state   <= (r_discard == OUT_W'(1'b1)) ? FQ_RUN : FQ_DRAIN;
                        end
                    end
                    FQ_RUN:  r_state <= FQ_RUN;
                    default: r_state <= FQ_RUN;
                endcase
            end
        end
    end

endmodule
